// File: rtl/cl2_trap_ctrl.sv
// Machine-mode trap controller: trap CSRs, exception/interrupt/MRET acceptance,
// and the IDLE -> FLUSH -> REDIRECT pipeline redirect handshake.
module cl2_trap_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_valid_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_soft_i,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    // mie/mip hold only the implemented bits, ordered {11, 7, 3}
    logic [2:0]  mie_q, mie_d;
    logic [2:0]  mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] target_q, target_d;

    logic        idle;
    logic        take_exc;
    logic        take_mret;
    logic        take_irq;
    logic        take_trap;
    logic [2:0]  irq_pend;
    logic [4:0]  irq_cause;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_vec;
    logic [31:0] mstatus_rd;
    logic [31:0] mie_rd;
    logic [31:0] mip_rd;

    assign idle      = (state_q == ST_IDLE);
    assign irq_pend  = mie_q & mip_q;
    assign take_exc  = idle & exc_valid_i;
    assign take_mret = idle & ~exc_valid_i & mret_valid_i;
    assign take_irq  = idle & ~exc_valid_i & ~mret_valid_i & mst_mie_q
                       & commit_valid_i & (|irq_pend);
    assign take_trap = take_exc | take_irq;

    // Interrupt priority: external, then software, then timer
    always_comb begin
        if (irq_pend[2]) begin
            irq_cause = 5'd11;
        end else if (irq_pend[0]) begin
            irq_cause = 5'd3;
        end else begin
            irq_cause = 5'd7;
        end
    end

    assign trap_cause = take_exc ? exc_cause_i : irq_cause;
    assign trap_pc    = take_exc ? exc_pc_i : commit_pc_i;
    assign trap_vec   = {mtvec_q[31:2], 2'b00}
                        + ((take_irq && (mtvec_q[1:0] == 2'b01))
                           ? {25'b0, trap_cause, 2'b00} : 32'h0);

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
    assign mie_rd     = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
    assign mip_rd     = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

    always_comb begin
        case (csr_addr_i)
            12'h300: csr_rdata_o = mstatus_rd;
            12'h304: csr_rdata_o = mie_rd;
            12'h305: csr_rdata_o = mtvec_q;
            12'h340: csr_rdata_o = mscratch_q;
            12'h341: csr_rdata_o = mepc_q;
            12'h342: csr_rdata_o = mcause_q;
            12'h343: csr_rdata_o = mtval_q;
            12'h344: csr_rdata_o = mip_rd;
            default: csr_rdata_o = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mip_d      = {irq_ext_i, irq_timer_i, irq_soft_i};
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        target_d   = target_q;

        case (state_q)
            ST_IDLE:     if (take_trap || take_mret) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Trap/MRET updates win; a same-cycle software write is dropped entirely
        if (take_trap) begin
            mepc_d     = trap_pc & ~32'h1;
            mcause_d   = {take_irq, 26'b0, trap_cause};
            mtval_d    = take_exc ? exc_tval_i : 32'h0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            target_d   = trap_vec;
        end else if (take_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            target_d   = mepc_q;
        end else if (csr_we_i) begin
            case (csr_addr_i)
                12'h300: begin
                    mst_mie_d  = csr_wdata_i[3];
                    mst_mpie_d = csr_wdata_i[7];
                end
                12'h304: mie_d      = {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
                12'h305: mtvec_d    = csr_wdata_i & ~32'h2;
                12'h340: mscratch_d = csr_wdata_i;
                12'h341: mepc_d     = csr_wdata_i & ~32'h1;
                12'h342: mcause_d   = csr_wdata_i;
                12'h343: mtval_d    = csr_wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            target_q   <= target_d;
        end
    end

    assign flush_o          = (state_q == ST_FLUSH);
    assign redirect_valid_o = (state_q == ST_REDIRECT);
    assign redirect_pc_o    = redirect_valid_o ? target_q : '0;
    assign busy_o           = ~idle;

endmodule
